// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the character-LCD driver.
// Contents: FSM state enum, queued command struct, io_lcd field positions,
// command queue depth (4 entries with LCD_FIFO_EN defined, else 1).
package lcd_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT} lcd_state_e;
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_cmd_t;
   localparam int LCD_ON_BIT      = 31;
   localparam int LCD_REQ_BIT     = 30;
   localparam int LCD_OVF_CLR_BIT = 29;
   localparam int LCD_RS_BIT      = 9;
`ifdef LCD_FIFO_EN
   localparam int LCD_FIFO_DEPTH  = 4;
`else
   localparam int LCD_FIFO_DEPTH  = 1;
`endif
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous command queue, parameterised depth.
// Ports: clk_i, rst_ni (async active-low), push_i/din_i write side,
// pop_i/dout_o read side (dout_o is the head entry), full_o, empty_o.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  logic     pop_i,
   input  lcd_cmd_t din_i,
   output lcd_cmd_t dout_o,
   output logic     full_o,
   output logic     empty_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   lcd_cmd_t r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic w_push, w_pop;
   assign full_o  = r_cnt == CW'(DEPTH);
   assign empty_o = r_cnt == '0;
   assign w_pop   = pop_i && !empty_o;
   assign w_push  = push_i && (!full_o || w_pop);
   assign dout_o  = r_mem[r_rp];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
         if (w_pop)  r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wp] <= din_i;
   end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: memory-mapped HD44780 write driver with command queue and bus timing.
// Ports: clk_i, rst_ni (async active-low); io_lcd_i core register
// ([31] ON, [30] REQ toggle, [29] OVF_CLR, [9] RS, [7:0] DATA);
// lcd_on_o/lcd_rs_o/lcd_rw_o/lcd_en_o/lcd_data_o LCD pins; busy_o, ovf_o status.
// Build option: LCD_FIFO_EN selects a 4-entry queue instead of a single holding register.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int TSU_CYC        = 2,
   parameter int PW_CYC         = 12,
   parameter int WAIT_SHORT_CYC = 2000,
   parameter int WAIT_LONG_CYC  = 80000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] io_lcd_i,
   output logic        lcd_on_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic [7:0]  lcd_data_o,
   output logic        busy_o,
   output logic        ovf_o
);
   localparam int CW = $clog2(WAIT_LONG_CYC + 1);
   lcd_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   lcd_cmd_t      r_cmd, w_head, w_din;
   logic          r_req, r_on, r_ovf;
   logic          w_req, w_pop, w_full, w_empty, w_long;
   logic          w_unused;
   assign w_unused   = &{1'b0, io_lcd_i[28:10], io_lcd_i[8]};
   assign w_req      = io_lcd_i[LCD_REQ_BIT] ^ r_req;
   assign w_din      = {io_lcd_i[LCD_RS_BIT], io_lcd_i[7:0]};
   // clear display (0x01) and return home (0x02/0x03) need the long execution wait
   assign w_long     = !r_cmd.rs && r_cmd.data[7:2] == 6'd0 && r_cmd.data != 8'd0;
   assign lcd_on_o   = r_on;
   assign lcd_rs_o   = r_cmd.rs;
   assign lcd_data_o = r_cmd.data;
   assign lcd_rw_o   = 1'b0;
   assign lcd_en_o   = r_state == ST_PULSE;
   assign busy_o     = r_state != ST_IDLE || !w_empty;
   assign ovf_o      = r_ovf;
   lcd_cmd_fifo #(.DEPTH(LCD_FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_req),
      .pop_i   (w_pop),
      .din_i   (w_din),
      .dout_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );
   // counter is loaded with (length-1) on state entry; the state ends when it reaches 0
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = CW'(TSU_CYC - 1);
         end
         ST_SETUP: if (r_cnt == '0) begin
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = CW'(PW_CYC - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         ST_PULSE: if (r_cnt == '0) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = CW'(TSU_CYC - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         ST_HOLD: if (r_cnt == '0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = w_long ? CW'(WAIT_LONG_CYC - 1) : CW'(WAIT_SHORT_CYC - 1);
         end else w_cnt_nxt = r_cnt - 1'b1;
         ST_WAIT: if (r_cnt == '0) w_state_nxt = ST_IDLE;
            else w_cnt_nxt = r_cnt - 1'b1;
         default: w_state_nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_cmd   <= '0;
         r_req   <= 1'b0;
         r_on    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req   <= io_lcd_i[LCD_REQ_BIT];
         r_on    <= io_lcd_i[LCD_ON_BIT];
         if (w_pop) r_cmd <= w_head;
         // clear has priority over a drop in the same cycle
         if (io_lcd_i[LCD_OVF_CLR_BIT]) r_ovf <= 1'b0;
         else if (w_req && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end
endmodule
